// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the load/store bus sequencer.
//   SZ_B / SZ_H / SZ_W : access size codes on req_size (2'b11 is rejected as misaligned)
//   lsu_state_e        : sequencer states (IDLE, BUS, RESP)
//   lsu_misaligned()   : alignment check applied when a request is accepted
package lsu_bus_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Signal bundle between the MEM stage, the load/store sequencer and the data bus.
//   req_*  : access request from the pipeline (req_ready back-pressure)
//   bus_*  : single-outstanding data bus cycle
//   resp_* : one-cycle completion with error flag and extracted load data
// Modports: slave = the sequencer itself, master = the surrounding pipeline/bus environment.
interface lsu_bus_ctrl_if;
    import lsu_bus_ctrl_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_rdata,
        output resp_valid, resp_err, resp_data
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_rdata,
        input  resp_valid, resp_err, resp_data
    );

endinterface

// File: rtl/lsu_bus_ctrl_lane_align.sv
// Combinational byte-lane alignment for the load/store sequencer.
//   size, addr_lo : access size and low address bits
//   sign          : sign-extend request for B/H loads
//   wdata         : LSB-aligned store data  -> wdata_rep (lane-replicated), wstrb (byte strobes)
//   rdata         : raw bus word            -> rdata_ext (lane extracted, extended to 32 bits)
// Optional feature macro: LSU_SIGNEXT_EN (when undefined, loads are always zero-extended).
module lsu_lane_align
    import lsu_bus_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic       ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

`ifdef LSU_SIGNEXT_EN
    assign ext = sign;
`else
    logic unused_sign;
    assign unused_sign = sign;
    assign ext = 1'b0;
`endif

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wstrb     = 4'b0000;
        wdata_rep = '0;
        rdata_ext = '0;
        case (size)
            SZ_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{ext & byte_lane[7]}}, byte_lane};
            end
            SZ_H: begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{ext & half_lane[15]}}, half_lane};
            end
            SZ_W: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store sequencer between the MEM stage and the data bus; one access in flight.
//   clk, rst : system clock, synchronous active-high reset
//   lsu      : request / bus / response bundle (slave modport)
//   TIMEOUT_CYC : BUS cycles waited for bus_ack before aborting with resp_err
// Optional feature macro: LSU_SIGNEXT_EN (sign-extend B/H loads when req_signed=1).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | req_ready high, waiting for an access
// BUS     | bus_req held with registered fields, waiting for ack/timeout
// RESP    | one-cycle resp_valid pulse, then back to IDLE
module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    lsu_bus_ctrl_if.slave lsu
);

    // Down-counter loaded on accept; zero marks the last BUS cycle allowed.
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYC - 1);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;

    logic [3:0]  strb;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;

    lsu_lane_align u_align (
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .sign      (sign_q),
        .wdata     (wdata_q),
        .rdata     (lsu.bus_rdata),
        .wstrb     (strb),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu.req_valid) begin
                    we_d    = lsu.req_we;
                    size_d  = lsu.req_size;
                    sign_d  = lsu.req_signed;
                    addr_d  = lsu.req_addr;
                    wdata_d = lsu.req_wdata;
                    data_d  = '0;
                    if (lsu_misaligned(lsu.req_size, lsu.req_addr[1:0])) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        err_d   = 1'b0;
                        cnt_d   = TO_LOAD;
                    end
                end
            end
            ST_BUS: begin
                // An ack in the final allowed cycle still completes normally.
                if (lsu.bus_ack) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    data_d  = we_q ? '0 : rdata_ext;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    data_d  = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lsu.req_ready  = (state_q == ST_IDLE);
        lsu.bus_req    = (state_q == ST_BUS);
        lsu.bus_we     = (state_q == ST_BUS) && we_q;
        lsu.bus_addr   = (state_q == ST_BUS) ? {addr_q[31:2], 2'b00} : '0;
        lsu.bus_wstrb  = ((state_q == ST_BUS) && we_q) ? strb : 4'b0000;
        lsu.bus_wdata  = ((state_q == ST_BUS) && we_q) ? wdata_rep : '0;
        lsu.resp_valid = (state_q == ST_RESP);
        lsu.resp_err   = (state_q == ST_RESP) && err_q;
        lsu.resp_data  = (state_q == ST_RESP) ? data_q : '0;
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_bus_ctrl_if bif ();

    lsu_bus_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (bif)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic push, input logic exp_err, input logic [31:0] exp_data);
        exp_t e;
        bif.req_valid  = 1'b1;
        bif.req_we     = we;
        bif.req_size   = size;
        bif.req_signed = sgn;
        bif.req_addr   = addr;
        bif.req_wdata  = wdata;
        if (push) begin
            e.err  = exp_err;
            e.data = exp_data;
            sb.push_back(e);
        end
        @(negedge clk);
        bif.req_valid = 1'b0;
    endtask

    // Waits (bounded) for resp_valid, pops the scoreboard and compares.
    task automatic wait_resp(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!bif.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_resp_valid"}, 32'(bif.resp_valid), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_err"}, 32'(bif.resp_err), 32'(e.err));
            chk({tag, "_data"}, bif.resp_data, e.data);
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(bif.resp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bif.req_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] sx_exp;
        bif.req_valid  = 1'b0;
        bif.req_we     = 1'b0;
        bif.req_size   = 2'b00;
        bif.req_signed = 1'b0;
        bif.req_addr   = '0;
        bif.req_wdata  = '0;
        bif.bus_ack    = 1'b0;
        bif.bus_rdata  = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bif.req_ready), 32'd1);
        chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bif.resp_err), 32'd0);
        chk("rst_resp_data", bif.resp_data, 32'd0);
        chk("rst_bus_addr", bif.bus_addr, 32'd0);
        chk("rst_wstrb", 32'(bif.bus_wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // byte load 0x102, ack in first BUS cycle
        issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1'b1, 1'b0, 32'h000000BB);
        chk("bl_bus_req", 32'(bif.bus_req), 32'd1);
        chk("bl_ready_low", 32'(bif.req_ready), 32'd0);
        chk("bl_bus_addr", bif.bus_addr, 32'h100);
        chk("bl_bus_we", 32'(bif.bus_we), 32'd0);
        chk("bl_wstrb", 32'(bif.bus_wstrb), 32'd0);
        bif.bus_rdata = 32'hAABBCCDD;
        bif.bus_ack   = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        wait_resp("bl", 0);

        // half store 0x6
        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h00001234, 1'b1, 1'b0, 32'h0);
        chk("hs_bus_we", 32'(bif.bus_we), 32'd1);
        chk("hs_bus_addr", bif.bus_addr, 32'h4);
        chk("hs_wstrb", 32'(bif.bus_wstrb), 32'b1100);
        chk("hs_wdata", bif.bus_wdata, 32'h12341234);
        bif.bus_ack = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        wait_resp("hs", 0);

        // byte store addr 1
        issue(1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFF_FFA5, 1'b1, 1'b0, 32'h0);
        chk("bs_wstrb", 32'(bif.bus_wstrb), 32'b0010);
        chk("bs_wdata", bif.bus_wdata, 32'hA5A5A5A5);
        chk("bs_bus_addr", bif.bus_addr, 32'h200);
        bif.bus_ack = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        wait_resp("bs", 0);

        // half load upper lane, unsigned
        issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b1, 1'b0, 32'h00008001);
        bif.bus_rdata = 32'h80017FFF;
        bif.bus_ack   = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        wait_resp("hl", 0);

        // misaligned word load addr 0x2: no bus cycle, immediate error
        issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("mw_no_bus_req", 32'(bif.bus_req), 32'd0);
        wait_resp("mw", 0);

        // misaligned half and size 11
        issue(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("mh_no_bus_req", 32'(bif.bus_req), 32'd0);
        wait_resp("mh", 0);
        issue(1'b1, 2'b11, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("m3_no_bus_req", 32'(bif.bus_req), 32'd0);
        wait_resp("m3", 0);

        // timeout with no ack: bus_req for exactly 4 cycles
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0);
        n = 0;
        while (bif.bus_req && n < 20) begin
            chk("to_addr_stable", bif.bus_addr, 32'h10);
            n++;
            @(negedge clk);
        end
        chk("to_cycles", 32'(n), 32'd4);
        wait_resp("to", 0);

        // ack on the 4th BUS cycle beats the timeout
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h11223344);
        repeat (3) @(negedge clk);
        chk("ta_still_bus", 32'(bif.bus_req), 32'd1);
        bif.bus_rdata = 32'h11223344;
        bif.bus_ack   = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        wait_resp("ta", 0);

        // ack while idle is ignored
        bif.bus_ack = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        chk("idle_ack_no_resp", 32'(bif.resp_valid), 32'd0);
        chk("idle_ack_ready", 32'(bif.req_ready), 32'd1);

        // reset in 2nd BUS cycle
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rb_bus_req", 32'(bif.bus_req), 32'd0);
        chk("rb_ready", 32'(bif.req_ready), 32'd1);
        chk("rb_no_resp", 32'(bif.resp_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rb_quiet", 32'(bif.resp_valid | bif.bus_req), 32'd0);
        end

        // signed byte load addr 0x3
`ifdef LSU_SIGNEXT_EN
        sx_exp = 32'hFFFFFF80;
`else
        sx_exp = 32'h00000080;
`endif
        issue(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 1'b1, 1'b0, sx_exp);
        bif.bus_rdata = 32'h80123456;
        bif.bus_ack   = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        wait_resp("sx", 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
